// File: rtl/victim_writeback_buffer_if.sv
// Interface bundling the eviction, memory-drain and lookup channels of victim_writeback_buffer.
// The buffer takes the slave modport; the victim cache/memory side takes master.
interface victim_writeback_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 27
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [LINE_W-1:0] in_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [TAG_W-1:0]  mem_tag;
  logic [LINE_W-1:0] mem_data;
  logic [TAG_W-1:0]  lookup_tag;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_tag, in_data, mem_ready, lookup_tag,
    input  in_ready, mem_valid, mem_tag, mem_data, lookup_hit, lookup_data, count
  );

  modport slave (
    input  in_valid, in_tag, in_data, mem_ready, lookup_tag,
    output in_ready, mem_valid, mem_tag, mem_data, lookup_hit, lookup_data, count
  );
endinterface

// File: rtl/victim_writeback_buffer.sv
// In-order writeback queue for dirty victim lines with combinational tag lookup for forwarding.
// Optional WB_COALESCE_EN: a push matching a pending non-head entry overwrites it in place.
module victim_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 27
) (
  input logic CLK,
  input logic RST,
  victim_writeback_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_reg  [DEPTH];
  logic [LINE_W-1:0] data_reg [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // Slots listed by age: index 0 is the head, higher indices are younger.
  logic [PTR_W-1:0]  age_idx [DEPTH];
  logic [DEPTH-1:0]  lookup_match;

  logic push;
  logic pop;
  logic coal_hit;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi]      = rd_ptr_reg + PTR_W'(gi);
      assign lookup_match[gi] = valid_reg[age_idx[gi]] && (tag_reg[age_idx[gi]] == bus.lookup_tag);
    end
  endgenerate

  always_comb begin
    bus.lookup_hit  = 1'b0;
    bus.lookup_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (lookup_match[k]) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = data_reg[age_idx[k]];
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic [DEPTH-1:0] coal_match;
  logic [PTR_W-1:0] coal_idx;

  // The head is excluded so that a line being offered to memory never changes under it.
  assign coal_match[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_coal
      assign coal_match[gi] = valid_reg[age_idx[gi]] && (tag_reg[age_idx[gi]] == bus.in_tag);
    end
  endgenerate

  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (coal_match[k]) begin
        coal_hit = bus.in_valid;
        coal_idx = age_idx[k];
      end
    end
  end
`else
  assign coal_hit = 1'b0;
`endif

  assign bus.in_ready  = (count_reg != FULL);
  assign bus.mem_valid = (count_reg != '0);
  assign bus.mem_tag   = tag_reg[rd_ptr_reg];
  assign bus.mem_data  = data_reg[rd_ptr_reg];
  assign bus.count     = count_reg;

  assign push = bus.in_valid && bus.in_ready && !coal_hit;
  assign pop  = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_reg[i]  <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= rd_ptr_reg + 1'b1;
      end
      if (push) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        tag_reg[wr_ptr_reg]   <= bus.in_tag;
        data_reg[wr_ptr_reg]  <= bus.in_data;
        wr_ptr_reg            <= wr_ptr_reg + 1'b1;
      end
`ifdef WB_COALESCE_EN
      if (coal_hit) begin
        data_reg[coal_idx] <= bus.in_data;
      end
`endif
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Directed self-checking bench for victim_writeback_buffer (default or WB_COALESCE_EN build).
module tb_victim_writeback_buffer;
  localparam int DEPTH  = 4;
  localparam int LINE_W = 256;
  localparam int TAG_W  = 27;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  victim_writeback_buffer_if #(.DEPTH(DEPTH), .LINE_W(LINE_W), .TAG_W(TAG_W)) bus ();

  victim_writeback_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .TAG_W(TAG_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_tag   = tag;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 'x;
    $display("push tag=%0h count=%0d", tag, bus.count);
  endtask

  task automatic pop_check(input string name, input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data);
    bus.mem_ready = 1'b1;
    #1;
    chk({name, "_valid"}, 256'(bus.mem_valid), 256'(1));
    chk({name, "_tag"}, 256'(bus.mem_tag), 256'(tag));
    chk({name, "_data"}, bus.mem_data, data);
    tick();
    bus.mem_ready = 1'b0;
    $display("pop tag=%0h count=%0d", tag, bus.count);
  endtask

  task automatic look(input string name, input logic [TAG_W-1:0] tag, input logic hit, input logic [LINE_W-1:0] data);
    bus.lookup_tag = tag;
    #1;
    chk({name, "_hit"}, 256'(bus.lookup_hit), 256'(hit));
    chk({name, "_data"}, bus.lookup_data, data);
    $display("lookup tag=%0h hit=%0b", tag, bus.lookup_hit);
  endtask

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] v);
    return {8{v}};
  endfunction

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_tag     = '0;
    bus.in_data    = '0;
    bus.mem_ready  = 1'b0;
    bus.lookup_tag = '0;
    #12;
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_count", 256'(bus.count), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_mem_valid", 256'(bus.mem_valid), 256'(0));
    chk("rst_mem_tag", 256'(bus.mem_tag), 256'(0));
    chk("rst_mem_data", bus.mem_data, 256'(0));
    look("rst_lookup", 27'h0, 1'b0, 256'(0));

    // Fill to full, reject a fifth push, drain in order
    push(27'h1, pat(32'h1111_0001));
    chk("first_latency_valid", 256'(bus.mem_valid), 256'(1));
    push(27'h2, pat(32'h1111_0002));
    push(27'h3, pat(32'h1111_0003));
    push(27'h4, pat(32'h1111_0004));
    chk("full_count", 256'(bus.count), 256'(4));
    chk("full_in_ready", 256'(bus.in_ready), 256'(0));
    push(27'h5, pat(32'h1111_0005));
    chk("overflow_count", 256'(bus.count), 256'(4));
    look("overflow_lookup", 27'h5, 1'b0, 256'(0));
    pop_check("drain1", 27'h1, pat(32'h1111_0001));
    pop_check("drain2", 27'h2, pat(32'h1111_0002));
    pop_check("drain3", 27'h3, pat(32'h1111_0003));
    pop_check("drain4", 27'h4, pat(32'h1111_0004));
    chk("drained_count", 256'(bus.count), 256'(0));
    chk("drained_valid", 256'(bus.mem_valid), 256'(0));

    // Reset with three entries pending
    push(27'h11, pat(32'h2222_0011));
    push(27'h12, pat(32'h2222_0012));
    push(27'h13, pat(32'h2222_0013));
    chk("pre_rst_count", 256'(bus.count), 256'(3));
    RST = 1'b1;
    #1;
    chk("async_rst_count", 256'(bus.count), 256'(0));
    tick();
    chk("mid_rst_count", 256'(bus.count), 256'(0));
    chk("mid_rst_valid", 256'(bus.mem_valid), 256'(0));
    look("mid_rst_lookup", 27'h11, 1'b0, 256'(0));
    RST = 1'b0;
    tick();
    chk("post_rst_valid", 256'(bus.mem_valid), 256'(0));

    // Backpressure holds head stable
    push(27'hA, pat(32'hDEAD_BEEF));
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 256'(bus.mem_valid), 256'(1));
      chk("bp_tag", 256'(bus.mem_tag), 256'(27'hA));
      chk("bp_data", bus.mem_data, pat(32'hDEAD_BEEF));
      tick();
    end
    pop_check("bp_pop", 27'hA, pat(32'hDEAD_BEEF));
    chk("bp_after_valid", 256'(bus.mem_valid), 256'(0));

    // Simultaneous push/pop at count=2 across wr_ptr wrap (slots 1,2 then 3,0)
    push(27'h21, pat(32'h3333_0021));
    push(27'h22, pat(32'h3333_0022));
    bus.mem_ready = 1'b1;
    push(27'h23, pat(32'h3333_0023));
    chk("simul1_count", 256'(bus.count), 256'(2));
    push(27'h24, pat(32'h3333_0024));
    chk("simul2_count", 256'(bus.count), 256'(2));
    bus.mem_ready = 1'b0;
    pop_check("wrap1", 27'h23, pat(32'h3333_0023));
    pop_check("wrap2", 27'h24, pat(32'h3333_0024));
    chk("wrap_count", 256'(bus.count), 256'(0));

    // Simultaneous push/pop at count=1
    push(27'h25, pat(32'h3333_0025));
    bus.mem_ready = 1'b1;
    push(27'h26, pat(32'h3333_0026));
    bus.mem_ready = 1'b0;
    chk("simul_c1_count", 256'(bus.count), 256'(1));
    pop_check("simul_c1_pop", 27'h26, pat(32'h3333_0026));

    // Lookup: hit, miss, hit during head pop, visibility one cycle after push
    push(27'h7, pat(32'hAAAA_0007));
    push(27'h9, pat(32'h9999_0009));
    look("lk_hit7", 27'h7, 1'b1, pat(32'hAAAA_0007));
    look("lk_miss8", 27'h8, 1'b0, 256'(0));
    bus.mem_ready = 1'b1;
    look("lk_pop7", 27'h7, 1'b1, pat(32'hAAAA_0007));
    tick();
    bus.mem_ready = 1'b0;
    look("lk_gone7", 27'h7, 1'b0, 256'(0));
    bus.in_valid = 1'b1;
    bus.in_tag   = 27'h30;
    bus.in_data  = pat(32'h3030_3030);
    look("lk_same_cycle", 27'h30, 1'b0, 256'(0));
    tick();
    bus.in_valid = 1'b0;
    look("lk_next_cycle", 27'h30, 1'b1, pat(32'h3030_3030));
    pop_check("lk_drain9", 27'h9, pat(32'h9999_0009));
    pop_check("lk_drain30", 27'h30, pat(32'h3030_3030));

    // Duplicate tag 0x9 behind head 0x3
    push(27'h3, pat(32'h0303_0303));
    push(27'h9, pat(32'hBBBB_BBBB));
    push(27'h9, pat(32'hCCCC_CCCC));
    look("dup_lookup", 27'h9, 1'b1, pat(32'hCCCC_CCCC));
`ifdef WB_COALESCE_EN
    chk("dup_count", 256'(bus.count), 256'(2));
    pop_check("dup_pop3", 27'h3, pat(32'h0303_0303));
    pop_check("dup_pop9", 27'h9, pat(32'hCCCC_CCCC));
`else
    chk("dup_count", 256'(bus.count), 256'(3));
    pop_check("dup_pop3", 27'h3, pat(32'h0303_0303));
    pop_check("dup_pop9b", 27'h9, pat(32'hBBBB_BBBB));
    pop_check("dup_pop9c", 27'h9, pat(32'hCCCC_CCCC));
`endif
    chk("dup_end_count", 256'(bus.count), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
